// File: rtl/seletor_rr_4.sv
// -----------------------------------------------------------------------------
// seletor_rr_4
//   Round-robin arbiter for four requesters sitting directly in front of a
//   4:1 data mux. It decides which source owns the shared path, keeps that
//   ownership stable while the owner needs it, and always leaves one idle
//   bubble cycle between owners so the mux output is never contended.
//
// Parameters
//   HOLD_MAX  maximum consecutive cycles a grant may be held (0 = unlimited)
//   CW        hold-counter width, 2**CW must exceed HOLD_MAX
//
// Ports
//   clock_i    system clock, rising edge
//   reset_i    asynchronous active-high reset, clears all state at once
//   enable_i   allows new grants; an ongoing grant is never aborted by it
//   req_i      request lines, req_i[i] = requester i wants the path
//   release_i  current owner is done (looked at only while a grant is held)
//   sel_o      index of the current / most recent owner, drives the mux SEL
//   grant_o    one-hot grant, 0000 while nobody owns the path
//   valid_o    high while a grant is active (valid_o == |grant_o)
//   timeout_o  one-cycle pulse after a grant was revoked by the hold limit
// -----------------------------------------------------------------------------
module seletor_rr_4 #(
  parameter int unsigned HOLD_MAX = 15,
  parameter int unsigned CW       = 4
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       enable_i,
  input  logic [3:0] req_i,
  input  logic       release_i,
  output logic [1:0] sel_o,
  output logic [3:0] grant_o,
  output logic       valid_o,
  output logic       timeout_o
);

  typedef enum logic [1:0] {
    OCIOSO    = 2'd0,  // idle, arbitrating
    CONCEDIDO = 2'd1,  // grant held
    TROCA     = 2'd2   // bubble cycle between owners
  } state_t;

  // Counter value on whose edge the hold limit expires. With HOLD_MAX = 0
  // the limit is disabled entirely, so the compare value is irrelevant.
  localparam bit          HOLD_EN       = (HOLD_MAX != 0);
  localparam int unsigned HOLD_LAST_INT = HOLD_EN ? (HOLD_MAX - 1) : 0;
  localparam logic [CW-1:0] HOLD_LAST   = HOLD_LAST_INT[CW-1:0];

  state_t        state_q;
  logic [1:0]    sel_q;
  logic [3:0]    grant_q;
  logic          valid_q;
  logic          timeout_q;
  logic [1:0]    last_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // ---------------------------------------------------------------------------
  // Round-robin pick: search last+1, last+2, last+3, last+4 (mod 4). The last
  // owner is therefore examined last and only wins when it is alone.
  // ---------------------------------------------------------------------------
  logic       pick_found;
  logic [1:0] pick_idx;
  logic [1:0] cand;

  always_comb begin
    pick_found = 1'b0;
    pick_idx   = last_q;
    cand       = last_q;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!pick_found && req_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Exit conditions while a grant is held.
  // ---------------------------------------------------------------------------
  logic owner_req;
  logic hold_expired;
  logic grant_end;

  assign owner_req    = req_i[sel_q];
  assign hold_expired = HOLD_EN && (cnt_q == HOLD_LAST);
  assign grant_end    = release_i || !owner_req || hold_expired;
  assign cnt_d        = cnt_q + CW'(1);

  // ---------------------------------------------------------------------------
  // FSM with registered outputs.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= OCIOSO;
      sel_q     <= 2'd0;
      grant_q   <= 4'b0000;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
      last_q    <= 2'd3;      // requester 0 gets first priority
      cnt_q     <= '0;
    end else begin
      // timeout is a single-cycle pulse; only the revoking edge sets it
      timeout_q <= 1'b0;
      case (state_q)
        OCIOSO: begin
          if (enable_i && pick_found) begin
            sel_q   <= pick_idx;
            grant_q <= 4'b0001 << pick_idx;
            valid_q <= 1'b1;
            last_q  <= pick_idx;
            cnt_q   <= '0;
            state_q <= CONCEDIDO;
          end
        end

        CONCEDIDO: begin
          if (grant_end) begin
            grant_q   <= 4'b0000;
            valid_q   <= 1'b0;
            // flag a revoke only when the limit alone ended the grant
            timeout_q <= hold_expired && !release_i && owner_req;
            state_q   <= TROCA;
          end else begin
            cnt_q <= cnt_d;
          end
        end

        TROCA: begin
          state_q <= OCIOSO;
        end

        default: begin
          state_q <= OCIOSO;
        end
      endcase
    end
  end

  assign sel_o     = sel_q;
  assign grant_o   = grant_q;
  assign valid_o   = valid_q;
  assign timeout_o = timeout_q;

endmodule

// File: tb/tb_seletor_rr_4.sv
// -----------------------------------------------------------------------------
// tb_seletor_rr_4
//   Randomized bench for seletor_rr_4. Inputs change after the falling edge,
//   a behavioural model advances on each rising edge and outputs are compared
//   on the following falling edge. Includes the reset-state check and an
//   asynchronous reset in the middle of a grant.
// -----------------------------------------------------------------------------
module tb_seletor_rr_4;

  localparam int HM = 5;   // hold limit used for this bench
  localparam int CWB = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] req = 4'b1111;
  logic       rel = 1'b0;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic       tmo;

  int n_total = 0;
  int n_bad   = 0;

  seletor_rr_4 #(.HOLD_MAX(HM), .CW(CWB)) dut (
    .clock_i  (clk),
    .reset_i  (rst),
    .enable_i (en),
    .req_i    (req),
    .release_i(rel),
    .sel_o    (sel),
    .grant_o  (grant),
    .valid_o  (valid),
    .timeout_o(tmo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: who owns the path, how long it has owned it, and whether
  // the path is in its post-grant cool-down cycle.
  // ---------------------------------------------------------------------------
  int m_owner;     // -1 when nobody owns the path
  int m_last;
  int m_sel;
  int m_cycles;    // cycles the current grant has been visible
  bit m_bubble;
  bit m_tmo;

  task automatic model_reset();
    m_owner  = -1;
    m_last   = 3;
    m_sel    = 0;
    m_cycles = 0;
    m_bubble = 0;
    m_tmo    = 0;
  endtask

  task automatic model_step(input bit e, input logic [3:0] r, input bit rl);
    bit by_rel, by_drop, by_time;
    int idx;
    m_tmo = 0;
    if (m_owner >= 0) begin
      by_rel  = rl;
      by_drop = !r[m_owner];
      by_time = (HM != 0) && (m_cycles == HM);
      if (by_rel || by_drop || by_time) begin
        m_tmo    = by_time && !by_rel && !by_drop;
        m_owner  = -1;
        m_bubble = 1;
      end else begin
        m_cycles++;
      end
    end else if (m_bubble) begin
      m_bubble = 0;
    end else if (e && r != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (m_owner < 0 && r[idx]) m_owner = idx;
      end
      m_last   = m_owner;
      m_sel    = m_owner;
      m_cycles = 1;
      $display("grant -> requester %0d at t=%0t", m_owner, $time);
    end
  endtask

  task automatic compare_all();
    logic [3:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    chk("sel",     32'(sel),   32'(m_sel));
    chk("grant",   32'(grant), 32'(eg));
    chk("valid",   32'(valid), 32'(m_owner >= 0));
    chk("timeout", 32'(tmo),   32'(m_tmo));
  endtask

  initial begin
    int  mode;
    bit  rst_done;
    rst_done = 0;
    model_reset();

    // reset held with all requests raised
    en  = 1'b1;
    req = 4'b1111;
    repeat (3) @(negedge clk);
    chk("rst_sel",     32'(sel),   32'd0);
    chk("rst_grant",   32'(grant), 32'd0);
    chk("rst_valid",   32'(valid), 32'd0);
    chk("rst_timeout", 32'(tmo),   32'd0);
    rst = 1'b0;

    for (int cyc = 0; cyc < 1600; cyc++) begin
      mode = cyc / 400;
      case (mode)
        0: begin  // everything random, requests sticky
          en = ($urandom_range(0, 9) < 8);
          if ($urandom_range(0, 4) == 0) req = 4'($urandom_range(0, 15));
          rel = ($urandom_range(0, 5) == 0);
        end
        1: begin  // all requesting, owners release at random
          en  = 1'b1;
          req = 4'b1111;
          rel = ($urandom_range(0, 2) == 0);
        end
        2: begin  // single holder never releasing -> hold-limit revokes
          en = 1'b1;
          if ($urandom_range(0, 9) == 0) req = 4'b0001 << $urandom_range(0, 3);
          if (req == 4'b0000) req = 4'b0010;
          rel = 1'b0;
        end
        default: begin  // enable toggling
          en = ($urandom_range(0, 1) == 1);
          if ($urandom_range(0, 6) == 0) req = 4'($urandom_range(0, 15));
          rel = ($urandom_range(0, 9) == 0);
        end
      endcase

      @(posedge clk);
      model_step(en, req, rel);
      @(negedge clk);
      compare_all();

      // asynchronous reset in the middle of a grant
      if (!rst_done && cyc >= 1300 && m_owner >= 0) begin
        rst_done = 1;
        #2 rst = 1'b1;
        #1;
        chk("midrst_grant",   32'(grant), 32'd0);
        chk("midrst_valid",   32'(valid), 32'd0);
        chk("midrst_sel",     32'(sel),   32'd0);
        chk("midrst_timeout", 32'(tmo),   32'd0);
        model_reset();
        req = 4'b1111;
        en  = 1'b1;
        rel = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        model_step(en, req, rel);
        @(negedge clk);
        compare_all();
        chk("post_rst_grant", 32'(grant), 32'b0001);
      end
    end
    chk("midrst_reached", 32'(rst_done), 32'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
